// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef logic [0:0] master_id_t;

  localparam master_id_t MASTER_FETCH = 1'b0;
  localparam master_id_t MASTER_LSU   = 1'b1;

  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  // Tie-break priority: the master named here wins when both are eligible.
  typedef enum logic {
    PRIO_FETCH = 1'b0,
    PRIO_LSU   = 1'b1
  } prio_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// One memory request port (address/data/strobes plus read return).
// Used for both upstream masters and the downstream mapper port.
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           write_data;
  logic [3:0]            byte_enable;
  logic                  write_req;
  logic                  read_req;
  logic                  ready;
  logic [31:0]           read_data;
  logic                  read_data_valid;

  modport master (
    output addr, write_data, byte_enable, write_req, read_req,
    input  ready, read_data, read_data_valid
  );

  modport slave (
    input  addr, write_data, byte_enable, write_req, read_req,
    output ready, read_data, read_data_valid
  );

  // Read-only fetch port: no write fields.
  modport fetch_master (
    output addr, read_req,
    input  ready, read_data, read_data_valid
  );

  modport fetch_slave (
    input  addr, read_req,
    output ready, read_data, read_data_valid
  );
endinterface

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order FIFO of master ids for outstanding reads; push+pop in one
// cycle keeps the count, pops on an empty FIFO are ignored.
module tag_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  master_id_t    push_data,
  input  logic          pop,
  output master_id_t    head,
  output logic [CW-1:0] count
);

  master_id_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: fetch (m0) and load/store (m1) onto one downstream port,
// with in-order read return routing. Optional MEM_ARBITER_PERF_COUNTERS_EN adds perf counters.
//
// state      | meaning
// PRIO_FETCH | last accepted transfer was m1; m0 wins a tie
// PRIO_LSU   | last accepted transfer was m0; m1 wins a tie
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_arbiter_if.fetch_slave       m0,
  mem_arbiter_if.slave             m1,
  mem_arbiter_if.master            ds,
  output logic                     tag_underflow
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
  ,
  output logic [31:0]              perf_m0_grants,
  output logic [31:0]              perf_m1_grants,
  output logic [31:0]              perf_read_stalls
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  prio_e           state;
  prio_e           state_nxt;
  logic [CW-1:0]   count;
  master_id_t      head;
  logic            read_ok;
  logic            m1_is_write;
  logic            elig0;
  logic            elig1;
  logic            grant0;
  logic            grant1;
  logic            xfer0;
  logic            xfer1;
  logic            push;
  logic            fifo_empty;
  logic [ADDR_WIDTH-1:0] fwd_addr;

  assign m1_is_write = m1.write_req;
  assign fifo_empty  = (count == '0);
  // A return in the same cycle frees a slot for a new issue.
  assign read_ok     = (count < CW'(MAX_OUTSTANDING)) | ds.read_data_valid;
  assign elig0       = m0.read_req & read_ok;
  assign elig1       = m1_is_write | (m1.read_req & read_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PRIO_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (xfer0)      state_nxt = PRIO_LSU;
    else if (xfer1) state_nxt = PRIO_FETCH;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = (state == PRIO_FETCH);
      grant1 = (state == PRIO_LSU);
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  always_comb begin
    fwd_addr          = '0;
    ds.write_data     = '0;
    ds.byte_enable    = '0;
    ds.write_req      = 1'b0;
    ds.read_req       = 1'b0;
    if (grant0) begin
      fwd_addr    = m0.addr;
      ds.read_req = 1'b1;
    end else if (grant1) begin
      fwd_addr       = m1.addr;
      ds.write_data  = m1.write_data;
      ds.byte_enable = m1.byte_enable;
      ds.write_req   = m1_is_write;
      ds.read_req    = ~m1_is_write;
    end
  end

  assign ds.addr  = fwd_addr;
  assign m0.ready = ds.ready & grant0;
  assign m1.ready = ds.ready & grant1;
  assign xfer0    = m0.ready;
  assign xfer1    = m1.ready;
  assign push     = xfer0 | (xfer1 & ~m1_is_write);

  tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (xfer1 ? MASTER_LSU : MASTER_FETCH),
    .pop       (ds.read_data_valid),
    .head      (head),
    .count     (count)
  );

  assign m0.read_data       = ds.read_data;
  assign m1.read_data       = ds.read_data;
  assign m0.read_data_valid = ds.read_data_valid & ~fifo_empty & (head == MASTER_FETCH);
  assign m1.read_data_valid = ds.read_data_valid & ~fifo_empty & (head == MASTER_LSU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          tag_underflow <= 1'b0;
    else if (ds.read_data_valid && fifo_empty && !push) tag_underflow <= 1'b1;
  end

`ifdef MEM_ARBITER_PERF_COUNTERS_EN
  logic read_stall;
  assign read_stall = (m0.read_req | (m1.read_req & ~m1_is_write)) & ~read_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_m0_grants   <= '0;
      perf_m1_grants   <= '0;
      perf_read_stalls <= '0;
    end else begin
      if (xfer0)      perf_m0_grants   <= perf_m0_grants + 32'd1;
      if (xfer1)      perf_m1_grants   <= perf_m1_grants + 32'd1;
      if (read_stall) perf_read_stalls <= perf_read_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus a random phase,
// compared against a queue-based reference model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tag_underflow;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32)) m0_bus ();
  mem_arbiter_if #(.ADDR_WIDTH(32)) m1_bus ();
  mem_arbiter_if #(.ADDR_WIDTH(32)) ds_bus ();

`ifdef MEM_ARBITER_PERF_COUNTERS_EN
  logic [31:0] perf_m0_grants, perf_m1_grants, perf_read_stalls;
`endif

  mem_arbiter #(.MAX_OUTSTANDING(4), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .ds            (ds_bus),
    .tag_underflow (tag_underflow)
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    ,
    .perf_m0_grants   (perf_m0_grants),
    .perf_m1_grants   (perf_m1_grants),
    .perf_read_stalls (perf_read_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding read owners in issue order, last granted master, sticky flag.
  int mq[$];
  int m_last = 1;
  bit m_uf = 1'b0;

  logic s_m0_ready, s_m1_ready, s_m0_valid, s_m1_valid, s_ds_wr;
  logic [31:0] s_ds_addr, s_m0_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 1;
    m_uf   = 1'b0;
  endtask

  // Called at a negedge: apply inputs, check combinational outputs, clock, update model.
  task automatic cycle(input bit m0rd, input logic [31:0] m0a,
                       input bit m1wr, input bit m1rd, input logic [31:0] m1a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input bit rdy, input bit rv, input logic [31:0] rdata);
    int sz;
    bit rok, el0, el1, g0, g1, wr, pushx;
    logic [31:0] e_addr;
    m0_bus.read_req = m0rd;  m0_bus.addr = m0a;
    m1_bus.write_req = m1wr; m1_bus.read_req = m1rd; m1_bus.addr = m1a;
    m1_bus.write_data = wd;  m1_bus.byte_enable = be;
    ds_bus.ready = rdy; ds_bus.read_data_valid = rv; ds_bus.read_data = rdata;
    #1;
    sz  = mq.size();
    rok = (sz < 4) || rv;
    wr  = m1wr;
    el0 = m0rd && rok;
    el1 = wr || (m1rd && rok);
    if (el0 && el1) begin g0 = (m_last == 1); g1 = !g0; end
    else begin g0 = el0; g1 = el1; end
    e_addr = g0 ? m0a : (g1 ? m1a : 32'h0);
    s_m0_ready = m0_bus.ready;  s_m1_ready = m1_bus.ready;
    s_m0_valid = m0_bus.read_data_valid; s_m1_valid = m1_bus.read_data_valid;
    s_ds_wr = ds_bus.write_req; s_ds_addr = ds_bus.addr; s_m0_data = m0_bus.read_data;
    chk("m0_ready", m0_bus.ready, rdy && g0);
    chk("m1_ready", m1_bus.ready, rdy && g1);
    chk("ds_addr", ds_bus.addr, e_addr);
    chk("ds_write_req", ds_bus.write_req, g1 && wr);
    chk("ds_read_req", ds_bus.read_req, g0 || (g1 && !wr));
    chk("ds_write_data", ds_bus.write_data, g1 ? wd : 32'h0);
    chk("ds_byte_enable", ds_bus.byte_enable, g1 ? be : 4'h0);
    chk("m0_valid", m0_bus.read_data_valid, rv && sz != 0 && mq[0] == 0);
    chk("m1_valid", m1_bus.read_data_valid, rv && sz != 0 && mq[0] == 1);
    chk("m1_read_data", m1_bus.read_data, rdata);
    chk("tag_underflow", tag_underflow, m_uf);
    @(posedge clk);
    if (!reset) begin
      pushx = rdy && (g0 || (g1 && !wr));
      if (rv && sz == 0 && !pushx) m_uf = 1'b1;
      if (rv && sz != 0) void'(mq.pop_front());
      if (pushx) mq.push_back(g0 ? 0 : 1);
      if (rdy && (g0 || g1)) m_last = g0 ? 0 : 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rv, input logic [31:0] rdata);
    cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, rv, rdata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("reset_underflow", tag_underflow, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    m0_bus.write_data = '0; m0_bus.byte_enable = '0; m0_bus.write_req = 1'b0;
    m0_bus.read_req = 1'b0; m0_bus.addr = '0;
    m1_bus.read_req = 1'b0; m1_bus.write_req = 1'b0; m1_bus.addr = '0;
    m1_bus.write_data = '0; m1_bus.byte_enable = '0;
    ds_bus.ready = 1'b0; ds_bus.read_data_valid = 1'b0; ds_bus.read_data = '0;
    @(negedge clk);
    do_reset();
    idle(0, 0);

    // Single fetch, data back two cycles later.
    cycle(1, 32'h1000_0000, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_issue", s_m0_ready, 1'b1);
    idle(0, 0);
    idle(1, 32'hDEAD_BEEF);
    chk("t1_m0_valid", s_m0_valid, 1'b1);
    chk("t1_m0_data", s_m0_data, 32'hDEAD_BEEF);
    chk("t1_m1_valid", s_m1_valid, 1'b0);

    // Both masters read every cycle: strict alternation starting with m0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h100 + i, 0, 1, 32'h200 + i, 0, 0, 1, 0, 0);
      chk("alt_m0", s_m0_ready, (i % 2) == 0);
      chk("alt_m1", s_m1_ready, (i % 2) == 1);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1, 32'hA000 + i);
      chk("alt_ret_m0", s_m0_valid, (i % 2) == 0);
      chk("alt_ret_m1", s_m1_valid, (i % 2) == 1);
    end

    // Fill the tag FIFO; writes still pass; a return frees a slot in-cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 32'h300 + i, 0, 0, 1, 0, 0);
      chk("fill_ready", s_m1_ready, 1'b1);
    end
    cycle(0, 0, 0, 1, 32'h304, 0, 0, 1, 0, 0);
    chk("full_held", s_m1_ready, 1'b0);
    cycle(0, 0, 1, 0, 32'h2000_0000, 32'h1234_5678, 4'hF, 1, 0, 0);
    chk("full_write_ready", s_m1_ready, 1'b1);
    chk("full_write_req", s_ds_wr, 1'b1);
    chk("full_write_addr", s_ds_addr, 32'h2000_0000);
    cycle(0, 0, 0, 1, 32'h304, 0, 0, 1, 1, 32'h5555);
    chk("ret_frees_slot", s_m1_ready, 1'b1);
    chk("ret_m1_valid", s_m1_valid, 1'b1);
    for (int i = 0; i < 4; i++) idle(1, 32'h6000 + i);

    // Downstream backpressure.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("bp_not_ready", s_m0_ready, 1'b0);
    end
    cycle(1, 32'h400, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("bp_accept", s_m0_ready, 1'b1);
    idle(1, 32'h77);
    chk("bp_single_ret", s_m0_valid, 1'b1);
    idle(1, 32'h78);
    chk("bp_no_extra", s_m0_valid, 1'b0);

    // Underflow is sticky until reset.
    do_reset();
    idle(1, 32'h99);
    chk("uf_no_m0_valid", s_m0_valid, 1'b0);
    chk("uf_no_m1_valid", s_m1_valid, 1'b0);
    idle(0, 0);
    idle(0, 0);
    chk("uf_sticky", tag_underflow, 1'b1);
    do_reset();
    chk("uf_cleared", tag_underflow, 1'b0);

    // Reset with two reads outstanding, last grant on m0.
    cycle(0, 0, 0, 1, 32'h500, 0, 0, 1, 0, 0);
    cycle(1, 32'h504, 0, 0, 0, 0, 0, 1, 0, 0);
    m0_bus.read_req = 1'b1; m1_bus.read_req = 1'b1; ds_bus.ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_tie_m0", m0_bus.ready, 1'b1);
    chk("rst_tie_m1", m1_bus.ready, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 32'h600 + i, 0, 0, 1, 0, 0);
      chk("rst_count_cleared", s_m1_ready, 1'b1);
    end
    for (int i = 0; i < 4; i++) idle(1, 32'h700 + i);

    // Random traffic against the model; returns only when reads are outstanding.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit rv;
      rv = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
            $urandom, $urandom, 4'($urandom), $urandom_range(0, 3) != 0, rv, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
